// File: rtl/serial_paralelo_sync_if.sv
// serial_paralelo_sync_if: serial input and parallel word output bundle of the serial-to-parallel converter.
interface serial_paralelo_sync_if #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             com_det;
    logic             active;
    modport master (output valid, data_in, input data_out, valid_out, com_det, active);
    modport slave  (input valid, data_in, output data_out, valid_out, com_det, active);
endinterface

// File: rtl/serial_paralelo_sync.sv
// serial_paralelo_sync: serial-to-parallel converter with COM-symbol word alignment and lock.
// Define SP_RELOCK_EN to drop lock after IDLE_LIMIT consecutive idle cycles.
module serial_paralelo_sync #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_SYMBOL = WIDTH'('hBC),
    parameter int               LOCK_COUNT = 4,
    parameter int               IDLE_LIMIT = 16
) (
    input logic                   clk_32f,
    input logic                   reset,
    serial_paralelo_sync_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    if (WIDTH < 2 || LOCK_COUNT < 1 || IDLE_LIMIT < 1) begin : g_bad_param
        $error("serial_paralelo_sync: invalid parameters");
    end

    typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    com_cnt_q, com_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic             com_det_q, com_det_d;
    logic [WIDTH-1:0] nxt;
    logic             word_done;
    logic             is_com;
    logic             idle_hit;

`ifdef SP_RELOCK_EN
    localparam int IW = $clog2(IDLE_LIMIT + 1);
    logic [IW-1:0] idle_cnt_q;
    logic [IW-1:0] idle_cnt_d;
    assign idle_cnt_d = (state_q == LOCKED && !bus.valid) ? idle_cnt_q + 1'b1 : '0;
    assign idle_hit   = idle_cnt_d == IW'(IDLE_LIMIT);
    always_ff @(posedge clk_32f or negedge reset)
        if (!reset) idle_cnt_q <= '0;
        else        idle_cnt_q <= idle_hit ? '0 : idle_cnt_d;
`else
    assign idle_hit = 1'b0;
`endif

    assign nxt       = {sr_q[WIDTH-2:0], bus.data_in};
    assign word_done = bit_cnt_q == BW'(WIDTH - 1);
    assign is_com    = nxt == COM_SYMBOL;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        com_cnt_d   = com_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        com_det_d   = 1'b0;
        if (bus.valid) begin
            sr_d = nxt;
            // HUNT searches bit by bit; ALIGN/LOCKED only look at word boundaries
            case (state_q)
                HUNT: if (is_com) begin
                    bit_cnt_d = '0;
                    com_cnt_d = CW'(1);
                    state_d   = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                end
                ALIGN: begin
                    bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
                    if (word_done) begin
                        com_cnt_d = is_com ? com_cnt_q + 1'b1 : '0;
                        state_d   = !is_com ? HUNT : (com_cnt_q + 1'b1 == CW'(LOCK_COUNT)) ? LOCKED : ALIGN;
                    end
                end
                LOCKED: begin
                    bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
                    if (word_done) begin
                        data_out_d  = nxt;
                        com_det_d   = is_com;
                        valid_out_d = !is_com;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (idle_hit) begin
            state_d   = HUNT;
            sr_d      = '0;
            bit_cnt_d = '0;
            com_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_32f or negedge reset)
        if (!reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            com_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            com_det_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            com_cnt_q   <= com_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            com_det_q   <= com_det_d;
        end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.com_det   = com_det_q;
    assign bus.active    = state_q == LOCKED;
endmodule
